// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 mouse front end.
// Idle level is high on the PS/2 clock line, so every front-end register resets to it.
package ps2_pkg;

    localparam int   PS2_FILTER_LEN  = 8;
    localparam int   PS2_SYNC_STAGES = 2;
    localparam logic PS2_IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        FILT_HOLD     = 2'd0,
        FILT_SET_HIGH = 2'd1,
        FILT_SET_LOW  = 2'd2
    } filt_action_e;

    // A window that is neither all-ones nor all-zeros is treated as noise, so the level holds.
    function automatic filt_action_e decodeWindow(input logic allOnes, input logic allZeros);
        filt_action_e action;
        action = FILT_HOLD;
        if (allOnes) begin
            action = FILT_SET_HIGH;
        end else if (allZeros) begin
            action = FILT_SET_LOW;
        end
        return action;
    endfunction

endpackage

// File: rtl/filtro_ruido_8bits_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input.
// Its reset value is a parameter so that a synchroniser leaving reset holds the line's idle level.
module sync_chain #(
    parameter int   N           = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {N{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/filtro_ruido_8bits.sv
// Noise filter and falling-edge detector for the PS/2 mouse clock line.
// The line is synchronised, debounced by requiring FILTER_LEN equal samples, and then edge-detected.
module filtro_ruido_8bits
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = PS2_SYNC_STAGES,
    parameter int FILTER_LEN  = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_c_mouse,
    output logic fall_edge
);

    logic                  w_sync_out;
    logic [FILTER_LEN-1:0] r_shreg;
    logic                  r_filt;
    logic                  r_filt_d;
    logic                  w_all_ones;
    logic                  w_all_zeros;
    logic                  w_filt_next;
    filt_action_e          w_action;

    sync_chain #(
        .N           (SYNC_STAGES),
        .RESET_VALUE (PS2_IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ps2_c_mouse),
        .o_q (w_sync_out)
    );

    assign w_all_ones  = &r_shreg;
    assign w_all_zeros = ~|r_shreg;

    always_comb begin
        w_action    = decodeWindow(w_all_ones, w_all_zeros);
        w_filt_next = r_filt;
        case (w_action)
            FILT_SET_HIGH: w_filt_next = 1'b1;
            FILT_SET_LOW:  w_filt_next = 1'b0;
            default:       w_filt_next = r_filt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= {FILTER_LEN{PS2_IDLE_LEVEL}};
            r_filt   <= PS2_IDLE_LEVEL;
            r_filt_d <= PS2_IDLE_LEVEL;
        end else begin
            r_shreg  <= {r_shreg[FILTER_LEN-2:0], w_sync_out};
            r_filt   <= w_filt_next;
            r_filt_d <= r_filt;
        end
    end

    // Decoded purely from registers, so the strobe has no combinational path from the pin.
    assign fall_edge = r_filt_d & ~r_filt;

endmodule

// File: tb/tb_filtro_ruido_8bits.sv
// Directed, scoreboard-driven bench for filtro_ruido_8bits (default build and a FILTER_LEN=4/SYNC_STAGES=3 build).
// Expected pulse cycles are queued when a deliberate falling edge is driven and popped when a pulse appears.
module tb_filtro_ruido_8bits;

    localparam int LAT_A = 2 + 8 + 1;
    localparam int LAT_B = 3 + 4 + 1;

    logic clk;
    logic rst;
    logic lineA;
    logic lineB;
    logic fallA;
    logic fallB;

    int total;
    int bad;
    int cyc;
    int qA[$];
    int qB[$];
    logic prevA;
    logic prevB;

    filtro_ruido_8bits dutA (
        .clk         (clk),
        .rst         (rst),
        .ps2_c_mouse (lineA),
        .fall_edge   (fallA)
    );

    filtro_ruido_8bits #(
        .SYNC_STAGES (3),
        .FILTER_LEN  (4)
    ) dutB (
        .clk         (clk),
        .rst         (rst),
        .ps2_c_mouse (lineB),
        .fall_edge   (fallB)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Pulse monitor for the default build: every pulse must be expected, on time and one cycle wide.
    initial prevA = 1'b0;
    always @(negedge clk) begin
        if (fallA === 1'b1) begin
            total++;
            assert (prevA !== 1'b1) else begin
                bad++;
                $error("[TB] FAIL A_width: observed second high cycle at cyc=%0d, expected single-cycle pulse", cyc);
            end
            total++;
            assert (qA.size() != 0) else begin
                bad++;
                $error("[TB] FAIL A_unexpected: observed pulse at cyc=%0d, expected no pulse", cyc);
            end
            if (qA.size() != 0) begin
                int expCyc;
                expCyc = qA.pop_front();
                total++;
                assert (cyc === expCyc) else begin
                    bad++;
                    $error("[TB] FAIL A_latency: observed pulse at cyc=%0d, expected cyc=%0d", cyc, expCyc);
                end
            end
        end
        prevA = fallA;
    end

    // Same checks for the short-filter build.
    initial prevB = 1'b0;
    always @(negedge clk) begin
        if (fallB === 1'b1) begin
            total++;
            assert (prevB !== 1'b1) else begin
                bad++;
                $error("[TB] FAIL B_width: observed second high cycle at cyc=%0d, expected single-cycle pulse", cyc);
            end
            total++;
            assert (qB.size() != 0) else begin
                bad++;
                $error("[TB] FAIL B_unexpected: observed pulse at cyc=%0d, expected no pulse", cyc);
            end
            if (qB.size() != 0) begin
                int expCyc;
                expCyc = qB.pop_front();
                total++;
                assert (cyc === expCyc) else begin
                    bad++;
                    $error("[TB] FAIL B_latency: observed pulse at cyc=%0d, expected cyc=%0d", cyc, expCyc);
                end
            end
        end
        prevB = fallB;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives the line, queues the expected pulse if asked, then holds for n cycles.
    task automatic applyStimulus(input bit sel, input logic v, input int n, input bit expectFall);
        if (sel) begin
            lineB = v;
            if (expectFall) qB.push_back(cyc + LAT_B);
        end else begin
            lineA = v;
            if (expectFall) qA.push_back(cyc + LAT_A);
        end
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        lineA = 1'b1;
        lineB = 1'b1;
        @(negedge clk);
        checkOutput("rst_filt", {31'd0, dutA.r_filt}, 32'd1);
        checkOutput("rst_filt_d", {31'd0, dutA.r_filt_d}, 32'd1);
        checkOutput("rst_shreg", {24'd0, dutA.r_shreg}, 32'hFF);
        checkOutput("rst_fall", {31'd0, fallA}, 32'd0);
        rst = 1'b0;

        $display("[TB] step 1: idle high after reset");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkOutput("t1_idle_fall", {31'd0, fallA}, 32'd0);
        end

        $display("[TB] step 2: reset with line low, then 40-cycle toggling");
        rst   = 1'b1;
        lineA = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 40, 1'b1);
        applyStimulus(1'b0, 1'b1, 40, 1'b0);
        applyStimulus(1'b0, 1'b0, 40, 1'b1);
        applyStimulus(1'b0, 1'b1, 40, 1'b0);
        applyStimulus(1'b0, 1'b0, 40, 1'b1);
        applyStimulus(1'b0, 1'b1, 40, 1'b0);
        checkOutput("t2_pending", qA.size(), 32'd0);

        $display("[TB] step 3: 7-cycle glitch rejected, 8-cycle low accepted");
        applyStimulus(1'b0, 1'b0, 7, 1'b0);
        applyStimulus(1'b0, 1'b1, 30, 1'b0);
        checkOutput("t3_glitch_filt", {31'd0, dutA.r_filt}, 32'd1);
        applyStimulus(1'b0, 1'b0, 8, 1'b1);
        applyStimulus(1'b0, 1'b1, 30, 1'b0);
        checkOutput("t3_pending", qA.size(), 32'd0);

        $display("[TB] step 4: low line with periodic single-cycle spikes");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 3, 1'b0);
            applyStimulus(1'b0, 1'b1, 1, 1'b0);
            checkOutput("t4_filt_hold", {31'd0, dutA.r_filt}, 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 30, 1'b0);

        $display("[TB] step 5: reset on the cycle the pulse would rise");
        applyStimulus(1'b0, 1'b0, 10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_fall", {31'd0, fallA}, 32'd0);
        checkOutput("t5_filt", {31'd0, dutA.r_filt}, 32'd1);
        checkOutput("t5_filt_d", {31'd0, dutA.r_filt_d}, 32'd1);
        checkOutput("t5_shreg", {24'd0, dutA.r_shreg}, 32'hFF);
        checkOutput("t5_sync", {30'd0, dutA.u_sync.r_sync}, 32'd3);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 20, 1'b1);
        applyStimulus(1'b0, 1'b1, 30, 1'b0);

        $display("[TB] step 6: FILTER_LEN=4, SYNC_STAGES=3 build");
        applyStimulus(1'b1, 1'b1, 20, 1'b0);
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        applyStimulus(1'b1, 1'b1, 20, 1'b0);
        checkOutput("t6_glitch_filt", {31'd0, dutB.r_filt}, 32'd1);
        applyStimulus(1'b1, 1'b0, 4, 1'b1);
        applyStimulus(1'b1, 1'b1, 20, 1'b0);
        applyStimulus(1'b1, 1'b0, 20, 1'b1);
        applyStimulus(1'b1, 1'b1, 20, 1'b0);

        checkOutput("end_pending_A", qA.size(), 32'd0);
        checkOutput("end_pending_B", qB.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
